// File: rtl/sensor_conditioner.sv
// Vehicle-sensor conditioner: synchronises and debounces four sensors, latches
// requests and issues a one-cycle advance pulse. Optional event counter: SEN_EVT_CNT_EN.
module sensor_conditioner #(
  parameter int DEB_CYCLES = 16,
  parameter int HOLDOFF    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_n,
  input  logic       raw_s,
  input  logic       raw_e,
  input  logic       raw_w,
  input  logic [1:0] cur_dir,
  output logic       sen,
  output logic [3:0] req,
  output logic [7:0] evt_cnt
);

  localparam logic [7:0]  DEB_LIM = 8'(DEB_CYCLES);
  localparam logic [15:0] HOLD_LD = 16'(HOLDOFF);

  logic [3:0]  w_raw;
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_deb;
  logic [3:0]  r_deb_d;
  logic [7:0]  r_deb_cnt [4];
  logic [3:0]  r_req;
  logic        r_sen;
  logic [15:0] r_holdoff;
  logic [1:0]  r_prev_dir;

  logic [3:0]  w_rise;
  logic [3:0]  w_dir_oh;
  logic [1:0]  w_next_dir;
  logic        w_dir_chg;
  logic        w_fire;

  // Bit index of every request vector equals the cur_dir encoding.
  assign w_raw = {raw_w, raw_e, raw_s, raw_n};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 4; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LIM) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Rotation is north -> east -> south -> west -> north.
  always_comb begin
    w_next_dir = 2'b00;
    case (cur_dir)
      2'b00:   w_next_dir = 2'b10;
      2'b10:   w_next_dir = 2'b01;
      2'b01:   w_next_dir = 2'b11;
      default: w_next_dir = 2'b00;
    endcase
  end

  assign w_rise    = r_deb & ~r_deb_d;
  assign w_dir_oh  = 4'b0001 << cur_dir;
  assign w_dir_chg = (cur_dir != r_prev_dir);
  assign w_fire    = (r_holdoff == 16'd0) && r_req[w_next_dir] &&
                     !r_req[cur_dir] && !w_dir_chg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req      <= '0;
      r_sen      <= 1'b0;
      r_holdoff  <= HOLD_LD;
      r_prev_dir <= cur_dir;
    end else begin
      // Clear for the green direction overrides a new rising edge.
      r_req      <= (r_req | w_rise) & ~w_dir_oh;
      r_sen      <= w_fire;
      r_prev_dir <= cur_dir;
      if (w_fire || w_dir_chg) begin
        r_holdoff <= HOLD_LD;
      end else if (r_holdoff != 16'd0) begin
        r_holdoff <= r_holdoff - 16'd1;
      end
    end
  end

  assign sen = r_sen;
  assign req = r_req;

`ifdef SEN_EVT_CNT_EN
  logic [7:0] r_evt_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_evt_cnt <= '0;
    end else if (w_fire && (r_evt_cnt != 8'hFF)) begin
      r_evt_cnt <= r_evt_cnt + 8'd1;
    end
  end

  assign evt_cnt = r_evt_cnt;
`else
  assign evt_cnt = 8'd0;
`endif

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 16, meaning consecutive stable cycles (1..255) a sensor must hold before its debounced level changes.
REQ-002 Parameter HOLDOFF, default 64, meaning minimum cycles (1..65535) between advance pulses and after any green-direction change.
REQ-003 clk  input  1  the one clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-005 raw_n, raw_s, raw_e, raw_w  input  1 each  asynchronous, bouncing vehicle-sensor inputs, active-high.
REQ-006 cur_dir  input  2  current green direction from the light controller: 00 north, 01 south, 10 east, 11 west.
REQ-007 sen  output  1  single-cycle advance pulse to the light controller.
REQ-008 req  output  4  latched pending requests, bit0 north, bit1 south, bit2 east, bit3 west.
REQ-009 evt_cnt  output  8  count of issued sen pulses (see Configuration).

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchroniser before any other logic.
REQ-011 Each channel SHALL keep an 8-bit debounce counter: cleared when the synchronised value equals the debounced level, otherwise incremented; when it reaches DEB_CYCLES, the debounced level takes the synchronised value and the counter clears.
REQ-012 Latency: a raw level held stable from edge k SHALL appear on the debounced level at edge k+2+DEB_CYCLES. Shorter glitches SHALL produce no change.
REQ-013 A debounced 0->1 transition SHALL set the matching req bit at the next edge.
REQ-014 A req bit SHALL be cleared, and SHALL NOT be set, on any edge where cur_dir selects that direction. Clear wins over a simultaneous set.
REQ-015 The rotation SHALL be north->east->south->west->north; next(cur_dir) denotes the successor.
REQ-016 A 16-bit holdoff counter SHALL load HOLDOFF on the edge that sen is driven high and on any edge where cur_dir differs from its registered previous value. Otherwise it SHALL decrement to 0 and stop.
REQ-017 sen SHALL be 1 for exactly one cycle when, at the preceding edge, the holdoff counter is 0, req[next(cur_dir)] is 1, and req[cur_dir] is 0. sen is registered.
REQ-018 If the next direction has no request, sen SHALL stay 0 even if other directions have requests; the controller's own timer serves them.
REQ-019 A cur_dir change in the same cycle as a sen-eligible condition SHALL suppress sen, and the holdoff reload SHALL take effect.
REQ-020 Requests arriving while the holdoff counter is nonzero SHALL stay latched and be acted on once it reaches 0.

Reset
REQ-021 While rst=0 at an edge: synchronisers, debounced levels, debounce counters and req SHALL become 0; sen SHALL become 0; evt_cnt SHALL become 0; the holdoff counter SHALL load HOLDOFF; the previous-cur_dir register SHALL load cur_dir.
REQ-022 Reset asserted mid-debounce or mid-holdoff SHALL discard all progress; no sen SHALL be issued for at least HOLDOFF cycles after release.

Configuration
REQ-023 Macro SEN_EVT_CNT_EN: when defined, evt_cnt SHALL increment on each sen pulse and saturate at 255. When undefined, evt_cnt SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-024 DEB_CYCLES=16: raw_e pulses high for 10 cycles -> debounced level and req[2] stay 0.
REQ-025 DEB_CYCLES=16, cur_dir=00: raw_e held high from edge k -> debounced level high at edge k+18, req=0100 at k+19.
REQ-026 HOLDOFF=64, cur_dir=00, req[0]=0, raw_e debounced after holdoff expiry -> sen=1 for exactly one cycle the edge after req[2] sets; a second pulse is issued no earlier than 64 cycles later.
REQ-027 cur_dir=00 with req=0001|0100 (north and east pending) -> sen stays 0; cur_dir->10 -> req[2] clears, holdoff reloads to 64.
REQ-028 cur_dir=00, only req[3] (west) pending, holdoff 0 -> sen stays 0 indefinitely.
REQ-029 rst=0 for 1 cycle while req=1111 and holdoff=5 -> req=0000, sen=0, holdoff=HOLDOFF; with SEN_EVT_CNT_EN, 300 sen pulses -> evt_cnt=255.
